// File: rtl/lc3_ea_sequencer.sv
// lc3_ea_sequencer: control FSM sequencing the LC-3 effective-address path
// (ADDR1/ADDR2/MARMUX selects) and the memory handshake with bounded wait.
`default_nettype none

module lc3_ea_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  input  logic [2:0]  i_nzp,
  input  logic        i_mem_ready,
  output logic [1:0]  o_addr2mux_select,
  output logic        o_addr1mux_select,
  output logic        o_gate_marmux,
  output logic        o_gate_mdr,
  output logic        o_ld_mar,
  output logic        o_ld_mdr,
  output logic        o_ld_pc,
  output logic        o_ld_reg,
  output logic        o_ld_cc,
  output logic [2:0]  o_dr_sel,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] c_WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_EA   = 3'd1;
  localparam logic [2:0] c_S_RD   = 3'd2;
  localparam logic [2:0] c_S_IND  = 3'd3;
  localparam logic [2:0] c_S_WR   = 3'd4;
  localparam logic [2:0] c_S_WB   = 3'd5;
  localparam logic [2:0] c_S_DONE = 3'd6;

  localparam logic [3:0] c_OP_BR  = 4'b0000;
  localparam logic [3:0] c_OP_LD  = 4'b0010;
  localparam logic [3:0] c_OP_ST  = 4'b0011;
  localparam logic [3:0] c_OP_JSR = 4'b0100;
  localparam logic [3:0] c_OP_LDR = 4'b0110;
  localparam logic [3:0] c_OP_STR = 4'b0111;
  localparam logic [3:0] c_OP_LDI = 4'b1010;
  localparam logic [3:0] c_OP_STI = 4'b1011;
  localparam logic [3:0] c_OP_JMP = 4'b1100;
  localparam logic [3:0] c_OP_LEA = 4'b1110;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [15:0]   r_ir;
  logic          r_ind;
  logic          r_err;
  logic [CW-1:0] r_wait;
  logic          w_set_err;
  logic          w_legal;
  logic          w_in_mem;
  logic          w_timeout;
  logic [3:0]    w_op;
  logic [3:0]    w_in_op;
  logic          w_unused;

  assign w_op      = r_ir[15:12];
  assign w_in_op   = i_ir[15:12];
  assign w_unused  = ^r_ir[8:0];
  assign w_in_mem  = (r_state == c_S_RD) || (r_state == c_S_WR);
  assign w_timeout = !i_mem_ready && (r_wait == c_WAIT_LAST);

  always_comb begin
    w_legal = 1'b0;
    case (w_in_op)
      c_OP_BR, c_OP_LD, c_OP_ST, c_OP_JSR, c_OP_LDR,
      c_OP_STR, c_OP_LDI, c_OP_STI, c_OP_JMP, c_OP_LEA: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // State register plus the datapath-side bookkeeping that travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_ir    <= 16'h0000;
      r_ind   <= 1'b0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_S_IDLE && i_start) begin
        r_ir  <= i_ir;
        r_ind <= w_legal && (w_in_op == c_OP_LDI || w_in_op == c_OP_STI);
      end else if (r_state == c_S_IND) begin
        r_ind <= 1'b0;
      end
      if (w_next == c_S_DONE) r_err <= w_set_err;
      if (w_in_mem && !i_mem_ready) r_wait <= r_wait + 1'b1;
      else                          r_wait <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (i_start) begin
          if (w_legal) begin
            w_next = c_S_EA;
          end else begin
            w_next    = c_S_DONE;
            w_set_err = 1'b1;
          end
        end
      end
      c_S_EA: begin
        case (w_op)
          c_OP_LEA, c_OP_BR, c_OP_JSR, c_OP_JMP: w_next = c_S_DONE;
          c_OP_ST, c_OP_STR:                     w_next = c_S_WR;
          default:                               w_next = c_S_RD;
        endcase
      end
      c_S_RD: begin
        if (i_mem_ready) begin
          w_next = r_ind ? c_S_IND : c_S_WB;
        end else if (w_timeout) begin
          w_next    = c_S_DONE;
          w_set_err = 1'b1;
        end
      end
      c_S_IND:  w_next = (w_op == c_OP_STI) ? c_S_WR : c_S_RD;
      c_S_WR: begin
        if (i_mem_ready) begin
          w_next = c_S_DONE;
        end else if (w_timeout) begin
          w_next    = c_S_DONE;
          w_set_err = 1'b1;
        end
      end
      c_S_WB:   w_next = c_S_DONE;
      c_S_DONE: w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    o_addr2mux_select = 2'b00;
    o_addr1mux_select = 1'b0;
    o_gate_marmux     = 1'b0;
    o_gate_mdr        = 1'b0;
    o_ld_mar          = 1'b0;
    o_ld_mdr          = 1'b0;
    o_ld_pc           = 1'b0;
    o_ld_reg          = 1'b0;
    o_ld_cc           = 1'b0;
    o_dr_sel          = 3'd0;
    o_mem_en          = 1'b0;
    o_mem_we          = 1'b0;
    o_busy            = (r_state != c_S_IDLE);
    o_done            = 1'b0;
    o_err             = 1'b0;
    case (r_state)
      c_S_EA: begin
        case (w_op)
          c_OP_LEA: begin
            o_addr2mux_select = 2'b10;
            o_gate_marmux     = 1'b1;
            o_ld_reg          = 1'b1;
            o_ld_cc           = 1'b1;
            o_dr_sel          = r_ir[11:9];
          end
          c_OP_BR: begin
            o_addr2mux_select = 2'b10;
            o_ld_pc           = |(r_ir[11:9] & i_nzp);
          end
          // R7 captures the PC before this edge's ld_pc takes effect.
          c_OP_JSR: begin
            o_addr2mux_select = r_ir[11] ? 2'b11 : 2'b00;
            o_addr1mux_select = !r_ir[11];
            o_ld_pc           = 1'b1;
            o_ld_reg          = 1'b1;
            o_dr_sel          = 3'd7;
          end
          c_OP_JMP: begin
            o_addr1mux_select = 1'b1;
            o_ld_pc           = 1'b1;
          end
          c_OP_LDR, c_OP_STR: begin
            o_addr2mux_select = 2'b01;
            o_addr1mux_select = 1'b1;
            o_gate_marmux     = 1'b1;
            o_ld_mar          = 1'b1;
          end
          default: begin
            o_addr2mux_select = 2'b10;
            o_gate_marmux     = 1'b1;
            o_ld_mar          = 1'b1;
          end
        endcase
      end
      c_S_RD: begin
        o_mem_en = 1'b1;
        o_ld_mdr = i_mem_ready;
      end
      c_S_IND: begin
        o_gate_mdr = 1'b1;
        o_ld_mar   = 1'b1;
      end
      c_S_WR: begin
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
      end
      c_S_WB: begin
        o_gate_mdr = 1'b1;
        o_ld_reg   = 1'b1;
        o_ld_cc    = 1'b1;
        o_dr_sel   = r_ir[11:9];
      end
      c_S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/lc3_ea_sequencer.md
# lc3_ea_sequencer

Multi-cycle control FSM that sequences the LC-3 effective-address path (ADDR1 base select, ADDR2 offset select, MARMUX) and the memory handshake for every address-forming instruction. It sits between instruction decode and the datapath, driving mux selects and register-load strobes from a latched IR. Memory accesses use a level handshake with a bounded-wait timeout.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles a memory access may wait for `mem_ready` (≥1).
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ir  in  16  instruction; latched on the accepted `start`.
- nzp  in  3  current condition codes {N,Z,P}.
- mem_ready  in  1  memory completed current access.
- addr2mux_select  out  2  00 zero, 01 sext ir[5:0], 10 sext ir[8:0], 11 sext ir[10:0].
- addr1mux_select  out  1  0 PC, 1 BaseR (ir[8:6]).
- gate_marmux  out  1  drive EA onto bus.
- gate_mdr  out  1  drive MDR onto bus.
- ld_mar, ld_mdr, ld_pc, ld_reg, ld_cc  out  1 each  register load strobes.
- dr_sel  out  3  destination register for `ld_reg`.
- mem_en  out  1  memory access request, held until `mem_ready`.
- mem_we  out  1  write qualifier, valid with `mem_en`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`: illegal opcode or memory timeout.

## Operation
- States: IDLE, EA, RD, IND, WR, WB, DONE. Flag `ind` (set for LDI/STI at start, cleared in IND).
- IDLE: `start`=1 → latch ir, go EA; opcode not in {BR,JSR,LD,LDI,LDR,LEA,ST,STI,STR,JMP} → DONE with err=1.
- EA selects: BR/LD/LDI/ST/STI/LEA → addr1=0, addr2=10; JSR (ir[11]=1) → addr1=0, addr2=11; JSRR/JMP → addr1=1, addr2=00; LDR/STR → addr1=1, addr2=01. Outside EA both selects are 0.
- EA actions/next:
  - LEA: gate_marmux, ld_reg, ld_cc, dr_sel=ir[11:9] → DONE.
  - BR: ld_pc = |(ir[11:9] & nzp) → DONE.
  - JSR/JSRR: ld_pc=1, ld_reg=1, dr_sel=7 (R7 captures pre-edge PC) → DONE.
  - JMP: ld_pc=1 → DONE.
  - LD/LDR/LDI/STI: gate_marmux, ld_mar → RD.
  - ST/STR: gate_marmux, ld_mar → WR.
- RD: mem_en=1, mem_we=0; on mem_ready: ld_mdr=1, next IND if ind else WB.
- IND: gate_mdr, ld_mar, clear ind; next RD for LDI, WR for STI.
- WR: mem_en=1, mem_we=1; on mem_ready → DONE. SR data path is the datapath's responsibility.
- WB: gate_mdr, ld_reg, ld_cc, dr_sel=ir[11:9] → DONE.
- DONE: done=1, err per cause; → IDLE.
- Timeout: wait counter cleared on entry to RD/WR, increments each cycle in RD/WR with mem_ready=0; after MEM_TIMEOUT consecutive low cycles → DONE, err=1, mem_en drops.
- `start` while busy is ignored; ir is not re-latched.

## Timing
- Reset: state IDLE, ind=0, counter 0, latched ir 0; all outputs 0.
- Outputs are Moore-decoded from state plus latched ir; strobes last exactly one cycle except mem_en/mem_we, which hold for the access.
- mem_ready is sampled at the rising edge while mem_en=1; ready in the first RD/WR cycle gives zero wait.
- Cycles from accepted start to done (zero-wait memory): LEA/BR/JMP/JSR 2, ST/STR 3, LD/LDR 4, STI 5, LDI 6; each wait cycle adds 1 per access.
- Illegal opcode: done+err on cycle 1 after start.
- Reset_n low mid-access: mem_en drops immediately (async); no done.

## Test plan
- Reset asserted mid-RD → all outputs 0 asynchronously; after release, state IDLE and busy=0.
- LDR ir=16'h6A45, mem_ready always 1 → cycle1 addr1=1 addr2=01 ld_mar; cycle2 mem_en ld_mdr; cycle3 ld_reg dr_sel=5 ld_cc; cycle4 done err=0.
- LDI ir=16'hA3FF with mem_ready delayed 2 cycles per access → addr2=10 in EA, two RD phases with IND between, done 10 cycles after start.
- BR ir=16'h0405, nzp=010 → ld_pc=1 in EA; nzp=001 → ld_pc=0; both done at cycle 2.
- ST ir=16'h3000, mem_ready held 0, MEM_TIMEOUT=15 → mem_en=mem_we=1 for 15 cycles, then done=1 err=1.
- Opcode 1101 → done=1 err=1 at cycle 1; start pulses during a running LD are ignored and ir stays unchanged.
